// File: rtl/sr_excite_driver.sv
// rtl/sr_excite_driver.sv - FIFO-fed S/R excitation driver with q feedback mismatch counter
// Optional feature macro: SR_REDRIVE_EN (re-assert excitation when target equals model)
module sr_excite_driver #(
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_bit,
  output logic            in_ready,
  input  logic            en,
  output logic            s,
  output logic            r,
  input  logic            q_fb,
  output logic            q_model,
  output logic            busy,
  output logic [ERRW-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          v1;
  logic          v2;
  logic          exp_q;
  logic          push;
  logic          pop;
  logic          tgt;

  // No bypass: readiness depends only on the pre-edge occupancy
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = en && (count != '0);
  assign tgt      = fifo_mem[rd_ptr];
  assign busy     = (count != '0) | v1 | v2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s       <= 1'b0;
      r       <= 1'b0;
      q_model <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      exp_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= in_bit;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // s and r are always complementary when driven, so 11 cannot occur
      s <= 1'b0;
      r <= 1'b0;
      if (pop) begin
        q_model <= tgt;
`ifdef SR_REDRIVE_EN
        s <= tgt;
        r <= ~tgt;
`else
        if (tgt != q_model) begin
          s <= tgt;
          r <= ~tgt;
        end
`endif
      end

      // q_fb reflects an excitation two edges after its pop
      v1    <= pop;
      v2    <= v1;
      exp_q <= q_model;
      if (v2 && (q_fb != exp_q) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sr_excite_driver.sv
// tb/tb_sr_excite_driver.sv - self-checking bench for sr_excite_driver with an attached srff model
module tb_sr_excite_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       en;
  logic       s;
  logic       r;
  logic       q_fb;
  logic       q_model;
  logic       busy;
  logic [1:0] err_cnt;
  logic       ff_q;
  logic       tie0;
  logic       saw_11;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sr_excite_driver #(.DEPTH(4), .ERRW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .en(en), .s(s), .r(r), .q_fb(q_fb), .q_model(q_model), .busy(busy), .err_cnt(err_cnt)
  );

  // Downstream srff sharing the driver's reset
  always @(posedge clk) begin
    if (!rst) ff_q <= 1'b0;
    else if (s && !r) ff_q <= 1'b1;
    else if (!s && r) ff_q <= 1'b0;
  end
  assign q_fb = tie0 ? 1'b0 : ff_q;

  initial saw_11 = 1'b0;
  always @(negedge clk) if (s && r) saw_11 = 1'b1;

  typedef struct {
    logic       rst, en, valid, din;
    logic       rdy, s, r, qm, busy;
    logic [1:0] err;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_sr(input logic t, input logic m);
    if (t != m) return t ? 2'b10 : 2'b01;
`ifdef SR_REDRIVE_EN
    return t ? 2'b10 : 2'b01;
`else
    return 2'b00;
`endif
  endfunction

  initial begin
    logic [5:0] bp_bits;
    logic [3:0] rd_bits;
    logic [1:0] sat_err [10];
    logic       m;
    int idx;
    bit was_ready;

    //            rst en  v  d   rdy s  r  qm busy err
    vecs[0]  = '{1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,2'd0};
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,2'd0};
    vecs[2]  = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b1,2'd0};
    vecs[3]  = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b1,2'd0};
    vecs[4]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,2'd0};
    vecs[5]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1,2'd0};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b1,2'd0};
    vecs[7]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1,1'b1,2'd0};
    vecs[8]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1,2'd0};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,2'd0};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,2'd0};
`ifdef SR_REDRIVE_EN
    vecs[4].s = 1'b1;
    vecs[6].r = 1'b1;
`endif

    tie0 = 1'b0;
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

    // Reset and basic 1,1,0,0,1 stream
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; in_valid = vecs[i].valid; in_bit = vecs[i].din;
      step();
      check($sformatf("v%0d in_ready", i), int'(in_ready), int'(vecs[i].rdy));
      check($sformatf("v%0d sr", i), int'({s, r}), int'({vecs[i].s, vecs[i].r}));
      check($sformatf("v%0d q_model", i), int'(q_model), int'(vecs[i].qm));
      check($sformatf("v%0d busy", i), int'(busy), int'(vecs[i].busy));
      check($sformatf("v%0d err_cnt", i), int'(err_cnt), int'(vecs[i].err));
    end

    // Backpressure: 6 bits offered with en low, then drained
    bp_bits = 6'b011010;
    en = 1'b0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_bit = bp_bits[idx];
      was_ready = in_ready;
      step();
      if (was_ready) idx++;
    end
    check("bp accepted", idx, 4);
    check("bp in_ready full", int'(in_ready), 0);
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (idx < 6); in_bit = bp_bits[idx < 6 ? idx : 0];
      was_ready = in_ready;
      step();
      if (was_ready && idx < 6) idx++;
      if (k == 0) check("bp in_ready after pop", int'(in_ready), 1);
      check($sformatf("bp pop%0d q_model", k), int'(q_model), int'(bp_bits[k]));
    end
    check("bp total accepted", idx, 6);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("bp drained busy", int'(busy), 0);
    check("bp err_cnt", int'(err_cnt), 0);

    // Saturation: q_fb forced 0, six targets of 1
    sat_err = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    tie0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = (k < 6); in_bit = 1'b1;
      step();
      check($sformatf("sat edge%0d err_cnt", k), int'(err_cnt), int'(sat_err[k]));
    end
    in_valid = 1'b0;

    // Mid-operation reset with 3 entries queued
    en = 1'b0; in_valid = 1'b1; in_bit = 1'b0;
    for (int k = 0; k < 3; k++) step();
    in_valid = 1'b0;
    check("mrst pre busy", int'(busy), 1);
    check("mrst pre q_model", int'(q_model), 1);
    rst = 1'b0;
    step();
    rst = 1'b1; en = 1'b1; tie0 = 1'b0;
    check("mrst in_ready", int'(in_ready), 1);
    check("mrst busy", int'(busy), 0);
    check("mrst sr", int'({s, r}), 0);
    check("mrst q_model", int'(q_model), 0);
    check("mrst err_cnt", int'(err_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mrst stale%0d sr", k), int'({s, r}), 0);
      check($sformatf("mrst stale%0d busy", k), int'(busy), 0);
    end

    // 1,1,0,0 stream: hold or re-drive depending on build
    rd_bits = 4'b0011;
    m = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 4); in_bit = rd_bits[k < 4 ? k : 0];
      step();
      if (k > 0) begin
        check($sformatf("rd pop%0d sr", k - 1), int'({s, r}), int'(exp_sr(rd_bits[k - 1], m)));
        m = rd_bits[k - 1];
        check($sformatf("rd pop%0d q_model", k - 1), int'(q_model), int'(m));
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("rd err_cnt", int'(err_cnt), 0);
    check("never 11", int'(saw_11), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sr_excite_driver.md
Name: sr_excite_driver

Overview:
- Transmit-side companion for the team's SR flip-flop (srff-style: s/r inputs, q output).
- Accepts a stream of target q values over a valid/ready handshake and buffers them in a small FIFO.
- Issues one legal S/R excitation per step so the downstream flop follows the stream; {s,r}=11 is never issued.
- Checks the flop's q feedback against an internal model and counts mismatches.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >=2.
- ERRW, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  target bit offered.
- in_bit  in  1  target q value.
- in_ready  out  1  FIFO can accept; equals !full.
- en  in  1  step enable; when 0, no FIFO pop occurs.
- s  out  1  set excitation, registered.
- r  out  1  reset excitation, registered.
- q_fb  in  1  q of the driven flop, sampled.
- q_model  out  1  expected flop state after the last issued excitation.
- busy  out  1  FIFO non-empty or check pipeline occupied.
- err_cnt  out  ERRW  saturating count of q_fb mismatches.

Behaviour:
- Reset (rst=0 at an edge) takes priority over everything, including mid-stream. It produces:
  - FIFO flushed (count=0).
  - s=0, r=0, q_model=0.
  - v1=v2=0, exp=0, err_cnt=0.
  - in_ready=1, busy=0 in the cycle after reset.
- The driven flop must share this reset and reset q to 0.
- Push: occurs at an edge when in_valid && in_ready.
- Pop: occurs at an edge when en && count>0, using the pre-edge count.
  - A push into an empty FIFO cannot pop at the same edge.
  - Minimum latency from accept to s/r change is 1 edge.
- Simultaneous push and pop: count is unchanged. A full FIFO stays not-ready that cycle (no bypass).
- Excitation at a pop, target t, model m:
  - t==m -> {s,r}=00 (hold).
  - t=1, m=0 -> 10.
  - t=0, m=1 -> 01.
  - q_model<=t at the same edge.
- At any edge without a pop, {s,r}<=00 and q_model holds.
- Check pipeline:
  - v1<=pop.
  - v2<=v1 and exp<=q_model.
  - At any edge where v2==1 and q_fb!=exp, err_cnt<=err_cnt+1, saturating at 2^ERRW-1 (no wrap).
  - Timing: pop at edge E0; the flop samples s/r at E1; q_fb is compared at E2.
- busy = (count!=0) | v1 | v2.
- FIFO uses DEPTH-entry storage with log2(DEPTH) pointers that wrap modulo DEPTH and a count of log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Pushes while in_ready=0 are ignored. Upstream must hold in_valid/in_bit until it sees in_ready.
- The s/r outputs never take value 11 under any input sequence.

Optional Feature:
- Macro: SR_REDRIVE_EN.
- Defined: the hold case is replaced by re-assertion. At a pop with t==m, drive 10 if t=1 and 01 if t=0; this restores a flop disturbed by an upset. All other rules are unchanged; no-pop edges still drive 00.
- Undefined: behaviour is exactly as in Behaviour above (t==m -> 00).

Test Plan:
- Reset values: hold rst=0 for 2 edges with in_valid=1.
  -> s=r=0, q_model=0, err_cnt=0, busy=0, no push occurs.
- Basic sequence: en=1; push 1,1,0,0,1 on consecutive cycles, with a real srff attached.
  -> {s,r} = 10,00,01,00,10 on successive cycles.
  -> q_model = 1,1,0,0,1; err_cnt stays 0.
- Backpressure (DEPTH=4): en=0; offer 6 bits with in_valid held.
  -> 4 accepted, in_ready=0 after the 4th.
  -> Raise en: one pop per cycle, in_ready=1 the cycle after the first pop; the remaining 2 bits are then accepted in order.
- Mismatch and saturation: ERRW=2, q_fb tied 0; push 1,1,1,1,1,1.
  -> err_cnt steps 1,2,3 then holds at 3, each step 2 edges after the corresponding pop.
- Mid-operation reset: FIFO holding 3 entries, pull rst=0 for one edge.
  -> count=0, s=r=0, q_model=0, err_cnt=0; no stale pops afterward.
- SR_REDRIVE_EN defined: push 1,1,0,0.
  -> {s,r} = 10,10,01,01; 11 is never seen.
